priority_encoder: RTL and testbench
===================================

# priority_encoder

Registered highest-index-wins priority encoder. Samples a request vector every clock, reports the index of the highest set bit together with a valid flag, one cycle later. It sits between raw request/interrupt lines and downstream selection or arbitration logic that needs a binary index and an "any request present" indication.

## Interface

Parameters:
- `WIDTH`, default 4: number of request lines. Must be a power of two and at least 2.
- `IDX_W`, default `$clog2(WIDTH)` (2 for the default): index output width. Derived; not overridden independently.

Ports:
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `d`, input, `WIDTH`: request vector. Bit i set means request i is active.
- `y`, output, `IDX_W`: binary index of the highest-numbered set bit of `d`, registered.
- `valid`, output, 1: high when at least one bit of `d` was set, registered.

## Operation

- **Priority.** The highest index wins. For the default `WIDTH=4`:
  - `d[3]` set → `y=11`
  - else `d[2]` set → `y=10`
  - else `d[1]` set → `y=01`
  - else `d[0]` set → `y=00`
- **Lower bits ignored.** Lower-priority bits have no effect once a higher bit is set. For example, `d=1100` → `y=11` and `d=0101` → `y=10`.
- **Valid flag.** `valid` = OR-reduction of `d`.
- **No request.** When `d=0`, `y` is forced to 0 and `valid` is 0. `y=00` with `valid=0` means "no request", which is distinct from `y=00` with `valid=1` (only `d[0]` set).
- **Encoder structure.** Implemented as a generic scan over `WIDTH` bits: ascending loop, last hit wins. No case statement hard-wired to 4 bits.
- **Statelessness.** No state other than the `y` and `valid` output registers. No history and no sticky requests; each sample is independent.
- **Unknowns.** `X`/`Z` on `d` is not a supported input. Behaviour then is don't-care, but reset must still clear the outputs.

## Timing

- **Latency.** Exactly 1 cycle. `d` is sampled at rising edge N; the `y`/`valid` result is visible after edge N and holds until edge N+1.
- **Throughput.** One new vector per cycle. No handshake and no back-pressure.
- **Reset.** When `rst=1` at a rising edge: `y` ← 0 and `valid` ← 0, regardless of `d`.
  - Reset has priority over the encode.
  - Asserting `rst` mid-stream discards the in-flight sample.
  - The first edge with `rst=0` captures the then-current `d`.
- **Before first reset.** Outputs are undefined until the first reset edge.
- **Glitch isolation.** Outputs change only on clock edges. Combinational glitches on `d` between edges are invisible.
- **Consecutive vectors.** Back-to-back different vectors each produce their own result on the following cycle. No merging.

## Test plan

1. **Reset.** Hold `rst=1` for 2 cycles with `d=1111`. Required: `y=00`, `valid=0`. Then release `rst`; after the next edge, `y=11`, `valid=1`.
2. **Single-hot sweep** (one vector per cycle): `d=0001`, `0010`, `0100`, `1000`. Required, each one cycle later: `y=00`, `01`, `10`, `11`, all with `valid=1`.
3. **Multi-hot priority:**
   - `d=1100` → `y=11`, `valid=1`
   - `d=0101` → `y=10`, `valid=1`
   - `d=0011` → `y=01`, `valid=1`
   - `d=1111` → `y=11`, `valid=1`
4. **Empty vector.** `d=0000` → `y=00`, `valid=0`. Then `d=0001` on the next cycle → `y=00`, `valid=1`; checks that the valid-flag distinction is observable.
5. **Back-to-back stream and mid-stream reset.**
   - Drive `0010`, `1100`, `0100`, `0010`, `0001`, `0101`, `0000` on consecutive cycles.
   - Required outputs one cycle later: `y` = `01`, `11`, `10`, `01`, `00`, `10`, `00`; `valid` = 1, 1, 1, 1, 1, 1, 0.
   - Repeat with `rst=1` asserted on the cycle that samples `0100`. That slot must read `y=00`, `valid=0`, and the stream must resume correctly afterwards.
6. **Exhaustive check.** All 16 values of `d` against a reference model (highest set bit, `valid` = OR), with a 1-cycle-delayed comparison. Also one instance at `WIDTH=8`: `d=0x90` → `y=111`; `d=0x01` → `y=000`, `valid=1`.

Source files
------------

// File: rtl/priority_encoder.sv
// Registered highest-index-wins priority encoder: samples d every clock and
// reports the index of the highest set bit plus an any-request flag one cycle later.
module priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [IDX_W-1:0] y,
  output logic             valid
);

  logic [IDX_W-1:0] idx_next;
  logic             any_next;

  // Ascending scan, so the last (highest) set bit overwrites earlier hits.
  always_comb begin
    idx_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) idx_next = i[IDX_W-1:0];
    end
    any_next = |d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      y     <= idx_next;
      valid <= any_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder at WIDTH=4 and WIDTH=8, using a
// queue of expected results popped one cycle after each vector is driven.
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic [1:0] y;
  logic       valid;
  logic [7:0] d8;
  logic [2:0] y8;
  logic       valid8;

  typedef struct packed {
    logic [2:0] y;
    logic       v;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  priority_encoder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .d(d), .y(y), .valid(valid)
  );

  priority_encoder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .d(d8), .y(y8), .valid(valid8)
  );

  // Reference: search downward from the top bit, stop at the first hit.
  function automatic exp_t model(input logic [7:0] dv, input int n, input logic r);
    exp_t e;
    e.y = 3'd0;
    e.v = 1'b0;
    if (!r) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (dv[i]) begin
          e.y = 3'(i);
          e.v = 1'b1;
          break;
        end
      end
    end
    return e;
  endfunction

  // Inputs change 1 time unit after the edge; outputs are read at the same offset.
  task automatic drive(input logic [3:0] dv, input logic [7:0] dv8, input logic r, input bit chk8);
    rst = r;
    d   = dv;
    d8  = dv8;
    q4.push_back(model({4'b0, dv}, 4, r));
    if (chk8) q8.push_back(model(dv8, 8, r));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 8'h00, 1'b1, 1'b0);
      e = q4.pop_front();
      total++;
      if (y !== 2'b00 || valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got y=%b valid=%b, need y=00 valid=0", i, y, valid);
      end
    end
    drive(4'b1111, 8'h00, 1'b0, 1'b0);
    e = q4.pop_front();
    total++;
    if (y !== e.y[1:0] || valid !== e.v) begin
      bad++;
      $display("FAIL reset_release: got y=%b valid=%b, need y=%b valid=%b", y, valid, e.y[1:0], e.v);
    end
  endtask

  task automatic test_single_hot;
    logic [3:0] v [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(v[i], 8'h00, 1'b0, 1'b0);
      e = q4.pop_front();
      total++;
      if (y !== e.y[1:0] || valid !== e.v) begin
        bad++;
        $display("FAIL single_hot d=%b: got y=%b valid=%b, need y=%b valid=%b", v[i], y, valid, e.y[1:0], e.v);
      end
    end
  endtask

  task automatic test_multi_hot;
    logic [3:0] v [4] = '{4'b1100, 4'b0101, 4'b0011, 4'b1111};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(v[i], 8'h00, 1'b0, 1'b0);
      e = q4.pop_front();
      total++;
      if (y !== e.y[1:0] || valid !== e.v) begin
        bad++;
        $display("FAIL multi_hot d=%b: got y=%b valid=%b, need y=%b valid=%b", v[i], y, valid, e.y[1:0], e.v);
      end
    end
  endtask

  task automatic test_empty;
    exp_t e;
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    e = q4.pop_front();
    total++;
    if (y !== 2'b00 || valid !== 1'b0 || y !== e.y[1:0] || valid !== e.v) begin
      bad++;
      $display("FAIL empty: got y=%b valid=%b, need y=00 valid=0", y, valid);
    end
    drive(4'b0001, 8'h00, 1'b0, 1'b0);
    e = q4.pop_front();
    total++;
    if (y !== 2'b00 || valid !== 1'b1 || y !== e.y[1:0] || valid !== e.v) begin
      bad++;
      $display("FAIL bit0_only: got y=%b valid=%b, need y=00 valid=1", y, valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] v  [7] = '{4'b0010, 4'b1100, 4'b0100, 4'b0010, 4'b0001, 4'b0101, 4'b0000};
    logic [1:0] ey [7] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 7; i++) begin
        logic r;
        logic [1:0] cy;
        logic       cv;
        r  = (pass == 1 && i == 2);
        cy = r ? 2'b00 : ey[i];
        cv = r ? 1'b0  : ev[i];
        drive(v[i], 8'h00, r, 1'b0);
        e = q4.pop_front();
        total++;
        if (y !== e.y[1:0] || valid !== e.v || y !== cy || valid !== cv) begin
          bad++;
          $display("FAIL stream pass%0d slot%0d d=%b rst=%b: got y=%b valid=%b, need y=%b valid=%b",
                   pass, i, v[i], r, y, valid, cy, cv);
        end
      end
    end
  endtask

  task automatic test_exhaustive;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 8'h00, 1'b0, 1'b0);
      e = q4.pop_front();
      total++;
      if (y !== e.y[1:0] || valid !== e.v) begin
        bad++;
        $display("FAIL exhaustive d=%b: got y=%b valid=%b, need y=%b valid=%b", 4'(i), y, valid, e.y[1:0], e.v);
      end
    end
  endtask

  task automatic test_width8;
    logic [7:0] v  [5] = '{8'h90, 8'h01, 8'h00, 8'h7F, 8'h24};
    logic [2:0] ey [5] = '{3'b111, 3'b000, 3'b000, 3'b110, 3'b101};
    logic       ev [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, v[i], 1'b0, 1'b1);
      e = q4.pop_front();
      e = q8.pop_front();
      total++;
      if (y8 !== e.y || valid8 !== e.v || y8 !== ey[i] || valid8 !== ev[i]) begin
        bad++;
        $display("FAIL width8 d=%h: got y=%b valid=%b, need y=%b valid=%b", v[i], y8, valid8, ey[i], ev[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    d   = 4'b1111;
    d8  = 8'hFF;
    #1;
    test_reset;
    test_single_hot;
    test_multi_hot;
    test_empty;
    test_back_to_back;
    test_exhaustive;
    test_width8;
    total++;
    if (q4.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got q4=%0d q8=%0d entries left, need 0", q4.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
